// File: rtl/pixel_gen.sv
// -----------------------------------------------------------------------------
// pixel_gen
// -----------------------------------------------------------------------------
// Pixel colour stage sitting right after the display timing generator.
// Everything runs on the single system clock 'clk'; the pixel clock coming
// from the timing block is sampled as ordinary data and its rising edge is
// turned into a one-clk strobe (pix_en) that advances all pixel logic.
//
// The picture is a yellow ship box drawn over a white pseudo-random
// starfield. Game logic hands over a new ship position with a valid/ready
// handshake. The position is parked in a shadow register and only becomes
// visible at the next frame start, so the ship never tears mid-frame.
//
// Optional feature (compile-time macro):
//   STARFIELD_SCROLL_EN  - when defined, the starfield seed advances one LFSR
//                          step per frame so the stars drift. When undefined
//                          the seed is the constant LFSR_SEED and the field
//                          is static.
//
// Ports
//   clk        in   1   system clock, the only clock
//   reset      in   1   asynchronous, active-high reset
//   p_clock    in   1   pixel clock from the timing block (sampled as data)
//   x, y       in   10  current pixel column / row
//   video_on   in   1   visible-area flag
//   vsync      in   1   vertical sync from the timing block
//   pos_x      in   10  requested ship x
//   pos_y      in   10  requested ship y
//   pos_valid  in   1   pos_x/pos_y are valid
//   pos_ready  out  1   block can accept a position
//   rgb        out  12  pixel colour {R[3:0],G[3:0],B[3:0]}
//   frame_tick out  1   one-clk pulse at the start of each frame
// -----------------------------------------------------------------------------
module pixel_gen #(
   parameter int unsigned SHIP_W    = 16,
   parameter int unsigned SHIP_H    = 16,
   parameter logic [9:0]  SHIP_X0   = 10'd312,
   parameter logic [9:0]  SHIP_Y0   = 10'd400,
   parameter logic [7:0]  STAR_MASK = 8'hFF,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_clock,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        video_on,
   input  logic        vsync,
   input  logic [9:0]  pos_x,
   input  logic [9:0]  pos_y,
   input  logic        pos_valid,
   output logic        pos_ready,
   output logic [11:0] rgb,
   output logic        frame_tick
);

   // Ship dimensions widened to 11 bits so that position + size never wraps
   // for a ship parked near the right/bottom edge of the 10-bit space.
   localparam logic [10:0] SHIP_W11 = 11'(SHIP_W);
   localparam logic [10:0] SHIP_H11 = 11'(SHIP_H);

   localparam logic [11:0] RGB_BLACK = 12'h000;
   localparam logic [11:0] RGB_SHIP  = 12'hFF0;
   localparam logic [11:0] RGB_STAR  = 12'hFFF;

   // One step of the 16-bit Fibonacci LFSR with taps 16,14,13,11.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic        p_clock_dly_q, p_clock_dly_d;
   logic        vsync_dly_q,   vsync_dly_d;
   logic        frame_tick_q,  frame_tick_d;

   logic [9:0]  act_x_q, act_x_d;
   logic [9:0]  act_y_q, act_y_d;
   logic [9:0]  shd_x_q, shd_x_d;
   logic [9:0]  shd_y_q, shd_y_d;
   logic        pending_q, pending_d;

   logic [15:0] lfsr_q, lfsr_d;
`ifdef STARFIELD_SCROLL_EN
   logic [15:0] seed_q, seed_d;
`endif

   logic        vld_s1_q,  vld_s1_d;
   logic        vid_s1_q,  vid_s1_d;
   logic        ship_s1_q, ship_s1_d;
   logic        star_s1_q, star_s1_d;
   logic [11:0] rgb_q,     rgb_d;

   logic        pix_en;
   logic        pos_xfer;
   logic        ship_hit;
   logic        star_hit;

   // ---------------------------------------------------------------------------
   // Pixel strobe and frame start detection.
   // The pixel clock is only looked at as data: its rising edge in the clk
   // domain is pix_en. vsync is also sampled on pix_en so its edge detector
   // moves at pixel rate, and frame_tick is registered to give a clean
   // single-clk pulse that the rest of the block keys off.
   // ---------------------------------------------------------------------------
   always_comb begin
      pix_en        = p_clock & ~p_clock_dly_q;
      p_clock_dly_d = p_clock;
      vsync_dly_d   = vsync_dly_q;
      frame_tick_d  = 1'b0;
      if (pix_en) begin
         vsync_dly_d  = vsync;
         frame_tick_d = vsync & ~vsync_dly_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Ship position handshake.
   // One position is accepted into the shadow register and then the block
   // refuses further ones until the frame start copies it into the active
   // register. A position offered exactly on the frame_tick clk bypasses the
   // shadow stage and becomes active for the frame that is starting.
   // ---------------------------------------------------------------------------
   always_comb begin
      pos_xfer  = pos_valid & ~pending_q;
      act_x_d   = act_x_q;
      act_y_d   = act_y_q;
      shd_x_d   = shd_x_q;
      shd_y_d   = shd_y_q;
      pending_d = pending_q;
      if (frame_tick_q) begin
         pending_d = 1'b0;
         if (pos_xfer) begin
            act_x_d = pos_x;
            act_y_d = pos_y;
            shd_x_d = pos_x;
            shd_y_d = pos_y;
         end else begin
            act_x_d = shd_x_q;
            act_y_d = shd_y_q;
         end
      end else if (pos_xfer) begin
         shd_x_d   = pos_x;
         shd_y_d   = pos_y;
         pending_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Starfield LFSR.
   // Advances once per visible pixel, so a given LFSR value always lands on
   // the same screen position. Reloading at frame start makes the pattern
   // repeat; with scrolling enabled the reload value itself advances one step
   // per frame, shifting the field by one visible pixel each frame.
   // frame_tick_q is high only on the clk after a pix_en, so the reload and
   // the per-pixel advance never compete in the same clk.
   // ---------------------------------------------------------------------------
   always_comb begin
      lfsr_d = lfsr_q;
`ifdef STARFIELD_SCROLL_EN
      seed_d = seed_q;
      if (frame_tick_q) begin
         seed_d = lfsr_step(seed_q);
         lfsr_d = lfsr_step(seed_q);
      end else if (pix_en && video_on) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
`else
      if (frame_tick_q) begin
         lfsr_d = LFSR_SEED;
      end else if (pix_en && video_on) begin
         lfsr_d = lfsr_step(lfsr_q);
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Two-stage colour pipeline.
   // S1 captures the hit flags for the current x/y (star test uses the LFSR
   // value before this pixel's advance). S2 resolves priority into rgb. Both
   // stages only move on pix_en so rgb is held steady between pixels.
   // ---------------------------------------------------------------------------
   always_comb begin
      ship_hit = ({1'b0, x} >= {1'b0, act_x_q}) &&
                 ({1'b0, x} <  ({1'b0, act_x_q} + SHIP_W11)) &&
                 ({1'b0, y} >= {1'b0, act_y_q}) &&
                 ({1'b0, y} <  ({1'b0, act_y_q} + SHIP_H11));
      star_hit = (lfsr_q[7:0] & STAR_MASK) == STAR_MASK;

      vld_s1_d  = vld_s1_q;
      vid_s1_d  = vid_s1_q;
      ship_s1_d = ship_s1_q;
      star_s1_d = star_s1_q;
      rgb_d     = rgb_q;

      if (pix_en) begin
         vld_s1_d  = 1'b1;
         vid_s1_d  = video_on;
         ship_s1_d = ship_hit;
         star_s1_d = star_hit;
         if (!vld_s1_q || !vid_s1_q) begin
            rgb_d = RGB_BLACK;
         end else if (ship_s1_q) begin
            rgb_d = RGB_SHIP;
         end else if (star_s1_q) begin
            rgb_d = RGB_STAR;
         end else begin
            rgb_d = RGB_BLACK;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers. Reset returns everything to the power-up picture
   // immediately, including clearing rgb without waiting for a pixel strobe.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_clock_dly_q <= 1'b0;
         vsync_dly_q   <= 1'b0;
         frame_tick_q  <= 1'b0;
         act_x_q       <= SHIP_X0;
         act_y_q       <= SHIP_Y0;
         shd_x_q       <= SHIP_X0;
         shd_y_q       <= SHIP_Y0;
         pending_q     <= 1'b0;
         lfsr_q        <= LFSR_SEED;
`ifdef STARFIELD_SCROLL_EN
         seed_q        <= LFSR_SEED;
`endif
         vld_s1_q      <= 1'b0;
         vid_s1_q      <= 1'b0;
         ship_s1_q     <= 1'b0;
         star_s1_q     <= 1'b0;
         rgb_q         <= RGB_BLACK;
      end else begin
         p_clock_dly_q <= p_clock_dly_d;
         vsync_dly_q   <= vsync_dly_d;
         frame_tick_q  <= frame_tick_d;
         act_x_q       <= act_x_d;
         act_y_q       <= act_y_d;
         shd_x_q       <= shd_x_d;
         shd_y_q       <= shd_y_d;
         pending_q     <= pending_d;
         lfsr_q        <= lfsr_d;
`ifdef STARFIELD_SCROLL_EN
         seed_q        <= seed_d;
`endif
         vld_s1_q      <= vld_s1_d;
         vid_s1_q      <= vid_s1_d;
         ship_s1_q     <= ship_s1_d;
         star_s1_q     <= star_s1_d;
         rgb_q         <= rgb_d;
      end
   end

   assign pos_ready  = ~pending_q;
   assign rgb        = rgb_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pixel_gen.sv
// -----------------------------------------------------------------------------
// tb_pixel_gen
// -----------------------------------------------------------------------------
// Self-checking bench for pixel_gen. Each pixel is presented by toggling
// p_clock high for two clk and low for two clk. A behavioural model computes
// the colour of every pixel from the picture rules (ship box, star test on
// the LFSR value, black outside the visible area) and the bench expects to
// see that colour on rgb one pixel later.
// -----------------------------------------------------------------------------
module tb_pixel_gen;

   localparam int SHIP_W  = 16;
   localparam int SHIP_H  = 16;
   localparam int SHIP_X0 = 312;
   localparam int SHIP_Y0 = 400;
   localparam int SEED    = 'hACE1;

   logic        clk = 1'b0;
   logic        reset;
   logic        p_clock;
   logic [9:0]  x;
   logic [9:0]  y;
   logic        video_on;
   logic        vsync;
   logic [9:0]  pos_x;
   logic [9:0]  pos_y;
   logic        pos_valid;
   logic        pos_ready;
   logic [11:0] rgb;
   logic        frame_tick;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state
   int          m_ax, m_ay, m_sx, m_sy, m_pending, m_lfsr, m_seed, m_vs_prev;
   logic [11:0] exp_prev;
   int          prev_x, prev_y, prev_rec, rec_frame;
   int          dut_s0[$], dut_s1[$], mdl_s0[$], mdl_s1[$];

   pixel_gen dut (
      .clk        (clk),
      .reset      (reset),
      .p_clock    (p_clock),
      .x          (x),
      .y          (y),
      .video_on   (video_on),
      .vsync      (vsync),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .pos_valid  (pos_valid),
      .pos_ready  (pos_ready),
      .rgb        (rgb),
      .frame_tick (frame_tick)
   );

   // 100 MHz system clock
   always #5 clk = ~clk;

   // Count and report one comparison
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Starfield generator step written as plain integer arithmetic
   function automatic int lfsrStep(input int s);
      int fb;
      fb = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
      return ((s << 1) | fb) & 'hFFFF;
   endfunction

   // Colour of one pixel given the current model picture state
   function automatic logic [11:0] colour(input int px, input int py, input int von);
      if (von == 0) return 12'h000;
      if (px >= m_ax && px < m_ax + SHIP_W && py >= m_ay && py < m_ay + SHIP_H)
         return 12'hFF0;
      if ((m_lfsr & 'hFF) == 'hFF) return 12'hFFF;
      return 12'h000;
   endfunction

   task automatic modelReset();
      m_ax = SHIP_X0; m_ay = SHIP_Y0;
      m_sx = SHIP_X0; m_sy = SHIP_Y0;
      m_pending = 0;
      m_lfsr = SEED;  m_seed = SEED;
      m_vs_prev = 0;
      exp_prev = 12'h000;
      prev_x = 0; prev_y = 0; prev_rec = -1;
   endtask

   // Present one pixel; optionally offer a position on the frame_tick clk
   task automatic applyStimulus(input int px, input int py, input int von, input int vs,
                                input int tick_pv, input int tpx, input int tpy);
      logic [11:0] exp_this;
      int          is_tick;
      x        = px[9:0];
      y        = py[9:0];
      video_on = (von != 0);
      vsync    = (vs != 0);
      p_clock  = 1'b1;
      exp_this = colour(px, py, von);
      if (von != 0) m_lfsr = lfsrStep(m_lfsr);
      is_tick   = (vs != 0 && m_vs_prev == 0) ? 1 : 0;
      m_vs_prev = vs;
      @(posedge clk); #1;
      checkOutput("rgb", {20'd0, rgb}, {20'd0, exp_prev});
      if (rgb === 12'hFFF && prev_rec == 0) dut_s0.push_back(prev_x * 1024 + prev_y);
      if (rgb === 12'hFFF && prev_rec == 1) dut_s1.push_back(prev_x * 1024 + prev_y);
      checkOutput("frame_tick_rise", {31'd0, frame_tick}, is_tick);
      if (is_tick != 0 && tick_pv != 0) begin
         pos_x     = tpx[9:0];
         pos_y     = tpy[9:0];
         pos_valid = 1'b1;
      end
      @(posedge clk); #1;
      if (is_tick != 0) begin
         if (tick_pv != 0 && m_pending == 0) begin
            m_ax = tpx; m_ay = tpy; m_sx = tpx; m_sy = tpy;
         end else begin
            m_ax = m_sx; m_ay = m_sy;
         end
         if (tick_pv != 0) pos_valid = 1'b0;
         m_pending = 0;
`ifdef STARFIELD_SCROLL_EN
         m_seed = lfsrStep(m_seed);
         m_lfsr = m_seed;
`else
         m_lfsr = SEED;
`endif
      end
      checkOutput("frame_tick_one_clk", {31'd0, frame_tick}, 0);
      checkOutput("pos_ready", {31'd0, pos_ready}, (m_pending != 0) ? 0 : 1);
      p_clock = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      if (exp_this == 12'hFFF && rec_frame == 0) mdl_s0.push_back(px * 1024 + py);
      if (exp_this == 12'hFFF && rec_frame == 1) mdl_s1.push_back(px * 1024 + py);
      exp_prev = exp_this;
      prev_x = px; prev_y = py; prev_rec = rec_frame;
   endtask

   // Frame start: a vsync pixel in blanking followed by a blank pixel
   task automatic startFrame(input int tick_pv, input int tpx, input int tpy);
      applyStimulus(0, 0, 0, 1, tick_pv, tpx, tpy);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Random pixels scattered around a point, mostly visible
   task automatic randomPixels(input int n, input int cx, input int cy);
      for (int i = 0; i < n; i++) begin
         applyStimulus((cx - 4 + $urandom_range(0, 24)) & 1023,
                       (cy - 4 + $urandom_range(0, 24)) & 1023,
                       ($urandom_range(0, 3) != 0) ? 1 : 0, 0, 0, 0, 0);
      end
   endtask

   // Small fixed raster window at the top-left of the screen
   task automatic rasterFrame();
      for (int yy = 0; yy < 20; yy++)
         for (int xx = 0; xx < 30; xx++)
            applyStimulus(xx, yy, 1, 0, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1; p_clock = 1'b0; x = '0; y = '0; video_on = 1'b0;
      vsync = 1'b0; pos_x = '0; pos_y = '0; pos_valid = 1'b0;
      rec_frame = -1;
      modelReset();

      // Outputs stay quiet while reset is held, even with pixel strobes and vsync
      for (int i = 0; i < 6; i++) begin
         p_clock = ~p_clock;
         vsync   = i[1];
         video_on = 1'b1;
         repeat (2) @(posedge clk);
         #1;
         checkOutput("reset_rgb", {20'd0, rgb}, 0);
         checkOutput("reset_pos_ready", {31'd0, pos_ready}, 1);
         checkOutput("reset_frame_tick", {31'd0, frame_tick}, 0);
      end
      p_clock = 1'b0; vsync = 1'b0; video_on = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Ship at reset position, right edge excluded
      applyStimulus(SHIP_X0, SHIP_Y0, 1, 0, 0, 0, 0);
      applyStimulus(SHIP_X0 + SHIP_W, SHIP_Y0, 1, 0, 0, 0, 0);
      checkOutput("ship_origin", {20'd0, rgb}, 12'hFF0);
      applyStimulus(SHIP_X0 + SHIP_W - 1, SHIP_Y0 + SHIP_H - 1, 1, 0, 0, 0, 0);
      checkOutput("ship_right_edge_excluded", {31'd0, (rgb == 12'hFF0)}, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("ship_far_corner", {20'd0, rgb}, 12'hFF0);
      randomPixels(40, SHIP_X0, SHIP_Y0);

      // Mid-frame handshake: one accept, then held valid is ignored
      pos_x = 10'd100; pos_y = 10'd50; pos_valid = 1'b1;
      @(posedge clk); #1;
      m_sx = 100; m_sy = 50; m_pending = 1;
      checkOutput("pos_ready_after_accept", {31'd0, pos_ready}, 0);
      pos_x = 10'd500; pos_y = 10'd500;
      applyStimulus(SHIP_X0, SHIP_Y0, 1, 0, 0, 0, 0);
      applyStimulus(100, 50, 1, 0, 0, 0, 0);
      checkOutput("ship_not_moved_yet", {20'd0, rgb}, 12'hFF0);
      randomPixels(20, 100, 50);
      pos_valid = 1'b0;
      startFrame(0, 0, 0);
      applyStimulus(115, 65, 1, 0, 0, 0, 0);
      applyStimulus(SHIP_X0, SHIP_Y0, 1, 0, 0, 0, 0);
      checkOutput("ship_moved", {20'd0, rgb}, 12'hFF0);
      randomPixels(40, 100, 50);

      // Position offered on the frame_tick clk is active for that frame
      startFrame(1, 200, 300);
      applyStimulus(200, 300, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("tick_same_clk_pos", {20'd0, rgb}, 12'hFF0);
      randomPixels(40, 200, 300);

      // Ship near the right edge must not wrap onto low x
      startFrame(1, 1020, 10);
      applyStimulus(3, 10, 1, 0, 0, 0, 0);
      applyStimulus(1020, 10, 0, 0, 0, 0, 0);
      checkOutput("no_wrap", {31'd0, (rgb == 12'hFF0)}, 0);
      applyStimulus(1023, 25, 1, 0, 0, 0, 0);
      checkOutput("video_off_black", {20'd0, rgb}, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("edge_corner_hit", {20'd0, rgb}, 12'hFF0);
      randomPixels(60, 1020, 10);

      // Two identical raster frames; record star coordinates
      rec_frame = 0;
      startFrame(0, 0, 0);
      rasterFrame();
      rec_frame = 1;
      startFrame(0, 0, 0);
      rasterFrame();
      rec_frame = -1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("stars_f0_count", dut_s0.size(), mdl_s0.size());
      checkOutput("stars_f1_count", dut_s1.size(), mdl_s1.size());
      for (int i = 0; i < dut_s0.size() && i < mdl_s0.size(); i++)
         checkOutput("stars_f0_xy", dut_s0[i], mdl_s0[i]);
      for (int i = 0; i < dut_s1.size() && i < mdl_s1.size(); i++)
         checkOutput("stars_f1_xy", dut_s1[i], mdl_s1[i]);
`ifndef STARFIELD_SCROLL_EN
      checkOutput("stars_repeat_count", dut_s1.size(), mdl_s0.size());
      for (int i = 0; i < dut_s1.size() && i < mdl_s0.size(); i++)
         checkOutput("stars_repeat_xy", dut_s1[i], mdl_s0[i]);
`endif

      // Reset mid-line with a position pending and a ship pixel on rgb
      pos_x = 10'd7; pos_y = 10'd7; pos_valid = 1'b1;
      @(posedge clk); #1;
      pos_valid = 1'b0;
      m_sx = 7; m_sy = 7; m_pending = 1;
      applyStimulus(1020, 10, 1, 0, 0, 0, 0);
      applyStimulus(40, 40, 1, 0, 0, 0, 0);
      checkOutput("rgb_before_reset", {20'd0, rgb}, 12'hFF0);
      reset = 1'b1;
      #1;
      checkOutput("rgb_async_reset", {20'd0, rgb}, 0);
      checkOutput("pos_ready_async_reset", {31'd0, pos_ready}, 1);
      checkOutput("frame_tick_async_reset", {31'd0, frame_tick}, 0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
      @(posedge clk); #1;
      randomPixels(30, SHIP_X0, SHIP_Y0);
      startFrame(0, 0, 0);
      randomPixels(40, SHIP_X0, SHIP_Y0);
      checkOutput("pos_after_reset_x", m_ax, SHIP_X0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
